// File: rtl/pmod_da2_tx_pkg.sv
// Shared types and frame constants for the PmodDA2 serial transmitter.
package da2_pkg;
  localparam int FRAME_BITS = 16;
  localparam logic [1:0] PD_NORMAL = 2'b00;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  // Frame word: {don't-care, power-down bits, sample}, MSB transmitted first.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [FRAME_BITS-1:0] sample,
                                                       input int dw);
    return sample | (FRAME_BITS'(PD_NORMAL) << dw);
  endfunction
endpackage

// File: rtl/pmod_da2_tx_if.sv
// Start/sample handshake between the sample-rate controller and the DAC transmitter.
interface pmod_da2_tx_if #(parameter int DATA_W = 12);
  logic              start;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              busy;
  logic              done;

  modport master (output start, data_a, data_b, input busy, done);
  modport slave  (input start, data_a, data_b, output busy, done);
endinterface

// File: rtl/pmod_da2_tx_sclk_strobe_gen.sv
// SCLK divider: toggles sclk every CLK_DIV cycles while enabled, idles high when not.
module sclk_strobe_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             tc;

  always_comb begin
    tc     = en && (div_q == DIV_TC);
    div_d  = '0;
    sclk_d = 1'b1;
    if (en) begin
      div_d  = tc ? '0 : div_q + 1'b1;
      sclk_d = tc ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  // Strobes mark the edge on which sclk is about to toggle, so the caller updates in lockstep.
  assign sclk     = sclk_q;
  assign rise_stb = tc & ~sclk_q;
  assign fall_stb = tc &  sclk_q;
endmodule

// File: rtl/pmod_da2_tx.sv
// Dual-channel PmodDA2 transmitter: captures two samples on start and shifts both out in one SYNC frame.
module pmod_da2_tx import da2_pkg::*; #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  pmod_da2_tx_if.slave      bus,
  output logic              sclk,
  output logic              ncs,
  output logic              dina,
  output logic              dinb
);
  localparam int GAP_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  // The done cycle itself completes the SYNC quiet time, so GAP stops one cycle short.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 2);

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   sr_a_q, sr_a_d, sr_b_q, sr_b_d;
  logic [4:0]              falls_q, falls_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    ncs_q, ncs_d, busy_q, busy_d, done_q, done_d;
  logic                    rise_stb, fall_stb;

  sclk_strobe_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == SHIFT),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_d = state_q;
    sr_a_d  = sr_a_q;
    sr_b_d  = sr_b_q;
    falls_d = falls_q;
    gap_d   = gap_q;
    ncs_d   = ncs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SHIFT;
        sr_a_d  = frame_word(FRAME_BITS'(bus.data_a), DATA_W);
        sr_b_d  = frame_word(FRAME_BITS'(bus.data_b), DATA_W);
        falls_d = '0;
        ncs_d   = 1'b0;
        busy_d  = 1'b1;
      end
      SHIFT: begin
        if (fall_stb) falls_d = falls_q + 1'b1;
        if (rise_stb) begin
          if (falls_q == 5'(FRAME_BITS)) begin
            state_d = GAP;
            ncs_d   = 1'b1;
            sr_a_d  = '0;
            sr_b_d  = '0;
            gap_d   = '0;
          end else begin
            sr_a_d = sr_a_q << 1;
            sr_b_d = sr_b_q << 1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_a_q  <= '0;
      sr_b_q  <= '0;
      falls_q <= '0;
      gap_q   <= '0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_a_q  <= sr_a_d;
      sr_b_q  <= sr_b_d;
      falls_q <= falls_d;
      gap_q   <= gap_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ncs      = ncs_q;
  assign dina     = sr_a_q[FRAME_BITS-1];
  assign dinb     = sr_b_q[FRAME_BITS-1];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_pmod_da2_tx.sv
// Directed bench: a DAC-side monitor decodes frames on SCLK falls; tasks compare against hand-computed words.
module tb_pmod_da2_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  pmod_da2_tx_if #(.DATA_W(12)) bus4 ();
  pmod_da2_tx_if #(.DATA_W(12)) bus1 ();
  logic sclk4, ncs4, dina4, dinb4, sclk1, ncs1, dina1, dinb1;

  pmod_da2_tx #(.CLK_DIV(4), .DATA_W(12)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .sclk(sclk4), .ncs(ncs4), .dina(dina4), .dinb(dinb4));
  pmod_da2_tx #(.CLK_DIV(1), .DATA_W(12)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .sclk(sclk1), .ncs(ncs1), .dina(dina1), .dinb(dinb1));

  // index 0 = CLK_DIV 4 instance, index 1 = CLK_DIV 1 instance
  logic [1:0] w_sclk, w_ncs, w_dina, w_dinb, w_done, w_busy;
  assign w_sclk = {sclk1, sclk4};
  assign w_ncs  = {ncs1, ncs4};
  assign w_dina = {dina1, dina4};
  assign w_dinb = {dinb1, dinb4};
  assign w_done = {bus1.done, bus4.done};
  assign w_busy = {bus1.busy, bus4.busy};

  logic [1:0]  p_sclk, p_ncs, p_done;
  logic [15:0] sh_a [2];
  logic [15:0] sh_b [2];
  int falls [2], low_len [2], high_len [2], last_fall [2], fall_gap [2];
  int done_long [2], done_busy [2];
  logic [15:0] fr_a [2][$];
  logic [15:0] fr_b [2][$];
  int fr_falls [2][$], fr_low [2][$], gap_len [2][$], done_at [2][$];

  initial begin
    for (int d = 0; d < 2; d++) begin
      done_long[d] = 0; done_busy[d] = 0; last_fall[d] = 0; fall_gap[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          p_sclk[d] = 1'b1; p_ncs[d] = 1'b1; p_done[d] = 1'b0;
          falls[d] = 0; low_len[d] = 0; high_len[d] = 0; sh_a[d] = '0; sh_b[d] = '0;
        end else begin
          if (p_ncs[d] && !w_ncs[d]) begin
            gap_len[d].push_back(high_len[d]);
            low_len[d] = 0; falls[d] = 0; sh_a[d] = '0; sh_b[d] = '0;
          end
          if (!p_ncs[d] && w_ncs[d]) begin
            fr_a[d].push_back(sh_a[d]); fr_b[d].push_back(sh_b[d]);
            fr_falls[d].push_back(falls[d]); fr_low[d].push_back(low_len[d]);
            high_len[d] = 0;
          end
          if (w_ncs[d]) high_len[d]++; else low_len[d]++;
          if (!w_ncs[d] && p_sclk[d] && !w_sclk[d]) begin
            sh_a[d] = {sh_a[d][14:0], w_dina[d]};
            sh_b[d] = {sh_b[d][14:0], w_dinb[d]};
            falls[d]++;
            fall_gap[d] = cyc - last_fall[d];
            last_fall[d] = cyc;
          end
          if (w_done[d] && !p_done[d]) begin
            done_at[d].push_back(cyc);
            if (w_busy[d]) done_busy[d]++;
          end
          if (w_done[d] && p_done[d]) done_long[d]++;
          p_sclk[d] = w_sclk[d]; p_ncs[d] = w_ncs[d]; p_done[d] = w_done[d];
        end
      end
    end
  end

  // e0 is the index of the clk edge that accepts start.
  task automatic pulse_start(input int d, input logic [11:0] a, input logic [11:0] b, output int e0);
    @(negedge clk);
    if (d == 0) begin bus4.start = 1'b1; bus4.data_a = a; bus4.data_b = b; end
    else        begin bus1.start = 1'b1; bus1.data_a = a; bus1.data_b = b; end
    e0 = cyc + 1;
    @(negedge clk);
    bus4.start = 1'b0; bus1.start = 1'b0;
  endtask

  task automatic wait_done(input int d, input int n, input int budget);
    int k = 0;
    while (done_at[d].size() < n && k < budget) begin @(negedge clk); k++; end
    nchk++;
    if (done_at[d].size() < n) begin
      nerr++; $display("FAIL done_timeout dut%0d got %0d dones, need %0d", d, done_at[d].size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nchk++; if (ncs4 !== 1'b1)  begin nerr++; $display("FAIL rst_ncs got %b exp 1", ncs4); end
    nchk++; if (sclk4 !== 1'b1) begin nerr++; $display("FAIL rst_sclk got %b exp 1", sclk4); end
    nchk++; if ({dina4, dinb4, dina1, dinb1} !== 4'b0) begin nerr++; $display("FAIL rst_din got %b exp 0000", {dina4, dinb4, dina1, dinb1}); end
    nchk++; if ({bus4.busy, bus4.done, bus1.busy, bus1.done} !== 4'b0) begin nerr++; $display("FAIL rst_flags got %b exp 0000", {bus4.busy, bus4.done, bus1.busy, bus1.done}); end
    nchk++; if ({ncs1, sclk1} !== 2'b11) begin nerr++; $display("FAIL rst_div1_idle got %b exp 11", {ncs1, sclk1}); end
    #2 rst = 1'b0;
    repeat (50) @(negedge clk);
    nchk++; if (done_at[0].size() + done_at[1].size() != 0) begin nerr++; $display("FAIL idle_done got %0d pulses exp 0", done_at[0].size() + done_at[1].size()); end
    nchk++; if ({ncs4, sclk4, dina4, dinb4, bus4.busy} !== 5'b11000) begin nerr++; $display("FAIL idle_pins got %b exp 11000", {ncs4, sclk4, dina4, dinb4, bus4.busy}); end
  endtask

  task automatic test_single();
    int e0; int n0 = fr_a[0].size(); int dn = done_at[0].size();
    pulse_start(0, 12'hA5C, 12'h3F0, e0);
    nchk++; if ({bus4.busy, ncs4, sclk4, dina4} !== 4'b1010) begin nerr++; $display("FAIL start_state got %b exp 1010", {bus4.busy, ncs4, sclk4, dina4}); end
    wait_done(0, dn + 1, 300);
    repeat (20) @(negedge clk);
    nchk++; if (((fr_a[0].size() > n0) ? fr_a[0][n0] : 16'hxxxx) !== 16'h0A5C) begin nerr++; $display("FAIL single_a got %h exp 0a5c", (fr_a[0].size() > n0) ? fr_a[0][n0] : 16'hxxxx); end
    nchk++; if (((fr_b[0].size() > n0) ? fr_b[0][n0] : 16'hxxxx) !== 16'h03F0) begin nerr++; $display("FAIL single_b got %h exp 03f0", (fr_b[0].size() > n0) ? fr_b[0][n0] : 16'hxxxx); end
    nchk++; if (((fr_falls[0].size() > n0) ? fr_falls[0][n0] : -1) != 16) begin nerr++; $display("FAIL single_falls got %0d exp 16", (fr_falls[0].size() > n0) ? fr_falls[0][n0] : -1); end
    nchk++; if (((fr_low[0].size() > n0) ? fr_low[0][n0] : -1) != 128) begin nerr++; $display("FAIL single_ncs_low got %0d exp 128", (fr_low[0].size() > n0) ? fr_low[0][n0] : -1); end
    nchk++; if (((done_at[0].size() > dn) ? done_at[0][dn] + 1 : -1) != e0 + 136) begin nerr++; $display("FAIL single_done_edge got %0d exp %0d", (done_at[0].size() > dn) ? done_at[0][dn] + 1 : -1, e0 + 136); end
    nchk++; if (done_at[0].size() != dn + 1 || done_long[0] != 0) begin nerr++; $display("FAIL single_done_pulse got %0d pulses %0d long exp 1 0", done_at[0].size() - dn, done_long[0]); end
    nchk++; if (done_busy[0] != 0) begin nerr++; $display("FAIL done_busy got %0d exp 0", done_busy[0]); end
  endtask

  task automatic test_ignore();
    int e0; int n0 = fr_a[0].size(); int dn = done_at[0].size();
    pulse_start(0, 12'hA5C, 12'h3F0, e0);
    while (cyc < e0 + 40) @(negedge clk);
    bus4.start = 1'b1; bus4.data_a = 12'h123; bus4.data_b = 12'h456;
    @(negedge clk);
    bus4.start = 1'b0;
    wait_done(0, dn + 1, 300);
    repeat (150) @(negedge clk);
    nchk++; if (((fr_a[0].size() > n0) ? fr_a[0][n0] : 16'hxxxx) !== 16'h0A5C) begin nerr++; $display("FAIL ignore_a got %h exp 0a5c", (fr_a[0].size() > n0) ? fr_a[0][n0] : 16'hxxxx); end
    nchk++; if (((fr_b[0].size() > n0) ? fr_b[0][n0] : 16'hxxxx) !== 16'h03F0) begin nerr++; $display("FAIL ignore_b got %h exp 03f0", (fr_b[0].size() > n0) ? fr_b[0][n0] : 16'hxxxx); end
    nchk++; if (done_at[0].size() != dn + 1 || fr_a[0].size() != n0 + 1) begin nerr++; $display("FAIL ignore_count got %0d dones %0d frames exp 1 1", done_at[0].size() - dn, fr_a[0].size() - n0); end
  endtask

  task automatic test_back_to_back();
    int e0; int n0 = fr_a[0].size(); int dn = done_at[0].size(); int g0 = gap_len[0].size();
    @(negedge clk);
    bus4.start = 1'b1; bus4.data_a = 12'hFFF; bus4.data_b = 12'h000;
    e0 = cyc + 1;
    while (cyc < e0 + 280) @(negedge clk);
    bus4.start = 1'b0;
    wait_done(0, dn + 3, 600);
    repeat (150) @(negedge clk);
    nchk++; if (fr_a[0].size() != n0 + 3) begin nerr++; $display("FAIL b2b_frames got %0d exp 3", fr_a[0].size() - n0); end
    for (int i = 0; i < 3; i++) begin
      nchk++; if (((fr_a[0].size() > n0 + i) ? fr_a[0][n0 + i] : 16'hxxxx) !== 16'h0FFF) begin nerr++; $display("FAIL b2b_a%0d got %h exp 0fff", i, (fr_a[0].size() > n0 + i) ? fr_a[0][n0 + i] : 16'hxxxx); end
      nchk++; if (((fr_b[0].size() > n0 + i) ? fr_b[0][n0 + i] : 16'hxxxx) !== 16'h0000) begin nerr++; $display("FAIL b2b_b%0d got %h exp 0000", i, (fr_b[0].size() > n0 + i) ? fr_b[0][n0 + i] : 16'hxxxx); end
      nchk++; if (((done_at[0].size() > dn + i) ? done_at[0][dn + i] + 1 : -1) != e0 + 136 * (i + 1)) begin nerr++; $display("FAIL b2b_done%0d got %0d exp %0d", i, (done_at[0].size() > dn + i) ? done_at[0][dn + i] + 1 : -1, e0 + 136 * (i + 1)); end
    end
    for (int i = 1; i < 3; i++) begin
      nchk++; if (((gap_len[0].size() > g0 + i) ? gap_len[0][g0 + i] : -1) != 8) begin nerr++; $display("FAIL b2b_gap%0d got %0d exp 8", i, (gap_len[0].size() > g0 + i) ? gap_len[0][g0 + i] : -1); end
    end
  endtask

  task automatic test_async_reset();
    int e0; int k = 0; int dn; int n0;
    pulse_start(0, 12'h5A3, 12'hC3C, e0);
    while (falls[0] < 7 && k < 200) begin @(negedge clk); k++; end
    nchk++; if (falls[0] < 7) begin nerr++; $display("FAIL arst_wait got %0d falls exp 7", falls[0]); end
    @(negedge clk);
    dn = done_at[0].size(); n0 = fr_a[0].size();
    #2 rst = 1'b1;
    #1;
    nchk++; if ({ncs4, sclk4, dina4, dinb4, bus4.busy} !== 5'b11000) begin nerr++; $display("FAIL arst_pins got %b exp 11000", {ncs4, sclk4, dina4, dinb4, bus4.busy}); end
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (60) @(negedge clk);
    nchk++; if (done_at[0].size() != dn || fr_a[0].size() != n0) begin nerr++; $display("FAIL arst_no_done got %0d dones %0d frames exp 0 0", done_at[0].size() - dn, fr_a[0].size() - n0); end
    pulse_start(0, 12'h5A3, 12'hC3C, e0);
    wait_done(0, dn + 1, 300);
    repeat (10) @(negedge clk);
    nchk++; if (((fr_a[0].size() > n0) ? fr_a[0][n0] : 16'hxxxx) !== 16'h05A3) begin nerr++; $display("FAIL arst_a got %h exp 05a3", (fr_a[0].size() > n0) ? fr_a[0][n0] : 16'hxxxx); end
    nchk++; if (((fr_b[0].size() > n0) ? fr_b[0][n0] : 16'hxxxx) !== 16'h0C3C) begin nerr++; $display("FAIL arst_b got %h exp 0c3c", (fr_b[0].size() > n0) ? fr_b[0][n0] : 16'hxxxx); end
    nchk++; if (((fr_falls[0].size() > n0) ? fr_falls[0][n0] : -1) != 16) begin nerr++; $display("FAIL arst_falls got %0d exp 16", (fr_falls[0].size() > n0) ? fr_falls[0][n0] : -1); end
  endtask

  task automatic test_div1();
    int e0; int n0 = fr_a[1].size(); int dn = done_at[1].size();
    pulse_start(1, 12'h801, 12'h7FE, e0);
    wait_done(1, dn + 1, 100);
    repeat (10) @(negedge clk);
    nchk++; if (((fr_a[1].size() > n0) ? fr_a[1][n0] : 16'hxxxx) !== 16'h0801) begin nerr++; $display("FAIL div1_a got %h exp 0801", (fr_a[1].size() > n0) ? fr_a[1][n0] : 16'hxxxx); end
    nchk++; if (((fr_b[1].size() > n0) ? fr_b[1][n0] : 16'hxxxx) !== 16'h07FE) begin nerr++; $display("FAIL div1_b got %h exp 07fe", (fr_b[1].size() > n0) ? fr_b[1][n0] : 16'hxxxx); end
    nchk++; if (((fr_low[1].size() > n0) ? fr_low[1][n0] : -1) != 32) begin nerr++; $display("FAIL div1_ncs_low got %0d exp 32", (fr_low[1].size() > n0) ? fr_low[1][n0] : -1); end
    nchk++; if (fall_gap[1] != 2) begin nerr++; $display("FAIL div1_sclk_period got %0d exp 2", fall_gap[1]); end
    nchk++; if (((done_at[1].size() > dn) ? done_at[1][dn] + 1 : -1) != e0 + 34) begin nerr++; $display("FAIL div1_done_edge got %0d exp %0d", (done_at[1].size() > dn) ? done_at[1][dn] + 1 : -1, e0 + 34); end
  endtask

  initial begin
    bus4.start = 1'b0; bus4.data_a = '0; bus4.data_b = '0;
    bus1.start = 1'b0; bus1.data_a = '0; bus1.data_b = '0;
    test_reset();
    test_single();
    test_ignore();
    test_back_to_back();
    test_async_reset();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog cycle %0d exceeded time limit", cyc);
    $fatal(1);
  end
endmodule
